// File: rtl/issue_sched.sv
// issue_sched: oldest-first selection of ALU, MUL and LOAD entries from the issue queue.
// Grants are registered; loads are held by a handshake FSM until the LSU accepts them.
module issue_sched #(
  parameter int CIQ_DEPTH = 16,
  parameter int AGE_WIDTH = 5,
  parameter int MUL_LAT   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CIQ_DEPTH-1:0]           req,
  input  logic [2*CIQ_DEPTH-1:0]         entry_type,
  input  logic [AGE_WIDTH*CIQ_DEPTH-1:0] entry_age,
  input  logic                           flush,
  input  logic                           lsu_ready,
  output logic                           alu0_vld,
  output logic                           alu1_vld,
  output logic                           mul_vld,
  output logic                           ld_vld,
  output logic [3:0]                     alu0_addr,
  output logic [3:0]                     alu1_addr,
  output logic [3:0]                     mul_addr,
  output logic [3:0]                     ld_addr,
  output logic                           mul_busy
);
  typedef enum logic {IDLE, WAIT} ld_st_e;
  localparam logic [CIQ_DEPTH-1:0] ONE = CIQ_DEPTH'(1);
  // returns {found, index}: minimum age wins, strict compare keeps the lowest index on ties
  function automatic logic [4:0] pick(input logic [CIQ_DEPTH-1:0] c,
                                      input logic [AGE_WIDTH*CIQ_DEPTH-1:0] a);
    logic                 f;
    logic [3:0]           idx;
    logic [AGE_WIDTH-1:0] best;
    f = 1'b0;
    idx = '0;
    best = '0;
    for (int i = 0; i < CIQ_DEPTH; i++)
      if (c[i] && (!f || a[AGE_WIDTH*i +: AGE_WIDTH] < best)) begin
        f = 1'b1;
        idx = 4'(i);
        best = a[AGE_WIDTH*i +: AGE_WIDTH];
      end
    return {f, idx};
  endfunction
  ld_st_e                 state_q, state_d;
  logic                   alu0_vld_q, alu0_vld_d, alu1_vld_q, alu1_vld_d, mul_vld_q, mul_vld_d;
  logic [3:0]             alu0_addr_q, alu0_addr_d, alu1_addr_q, alu1_addr_d;
  logic [3:0]             mul_addr_q, mul_addr_d, ld_addr_q, ld_addr_d;
  logic                   ld_acc_vld_q, ld_acc_vld_d;
  logic [3:0]             ld_acc_addr_q, ld_acc_addr_d;
  logic [3:0]             mul_cnt_q, mul_cnt_d;
  logic [CIQ_DEPTH-1:0]   is_alu, is_mul, is_ld, mask, elig;
  logic [4:0]             alu0_p, alu1_p, mul_p, ld_p;
  logic                   ld_take;
  always_comb begin
    is_alu = '0;
    is_mul = '0;
    is_ld = '0;
    for (int i = 0; i < CIQ_DEPTH; i++) begin
      is_alu[i] = entry_type[2*i +: 2] == 2'd0;
      is_mul[i] = entry_type[2*i +: 2] == 2'd1;
      is_ld[i]  = entry_type[2*i +: 2] == 2'd2;
    end
  end
  assign mask = ({CIQ_DEPTH{alu0_vld_q}}     & (ONE << alu0_addr_q))
              | ({CIQ_DEPTH{alu1_vld_q}}     & (ONE << alu1_addr_q))
              | ({CIQ_DEPTH{mul_vld_q}}      & (ONE << mul_addr_q))
              | ({CIQ_DEPTH{state_q == WAIT}} & (ONE << ld_addr_q))
              | ({CIQ_DEPTH{ld_acc_vld_q}}   & (ONE << ld_acc_addr_q));
  assign elig    = req & ~mask;
  assign alu0_p  = pick(elig & is_alu, entry_age);
  assign alu1_p  = pick(elig & is_alu & ~(ONE << alu0_p[3:0]), entry_age);
  assign mul_p   = pick(elig & is_mul, entry_age);
  assign ld_p    = pick(elig & is_ld, entry_age);
  assign ld_take = state_q == IDLE || lsu_ready;
  always_comb begin
    state_d = flush ? IDLE : ld_take ? (ld_p[4] ? WAIT : IDLE) : WAIT;
  end
  always_comb begin
    alu0_vld_d    = !flush && alu0_p[4];
    alu0_addr_d   = alu0_vld_d ? alu0_p[3:0] : alu0_addr_q;
    alu1_vld_d    = !flush && alu1_p[4];
    alu1_addr_d   = alu1_vld_d ? alu1_p[3:0] : alu1_addr_q;
    mul_vld_d     = !flush && mul_cnt_q <= 4'd1 && mul_p[4];
    mul_addr_d    = mul_vld_d ? mul_p[3:0] : mul_addr_q;
    mul_cnt_d     = flush ? 4'd0 : mul_vld_d ? 4'(MUL_LAT) : mul_cnt_q != 4'd0 ? mul_cnt_q - 4'd1 : mul_cnt_q;
    ld_addr_d     = (!flush && ld_take && ld_p[4]) ? ld_p[3:0] : ld_addr_q;
    ld_acc_vld_d  = !flush && state_q == WAIT && lsu_ready;
    ld_acc_addr_d = ld_acc_vld_d ? ld_addr_q : ld_acc_addr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= IDLE;
      alu0_vld_q    <= 1'b0;
      alu1_vld_q    <= 1'b0;
      mul_vld_q     <= 1'b0;
      alu0_addr_q   <= '0;
      alu1_addr_q   <= '0;
      mul_addr_q    <= '0;
      ld_addr_q     <= '0;
      ld_acc_vld_q  <= 1'b0;
      ld_acc_addr_q <= '0;
      mul_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      alu0_vld_q    <= alu0_vld_d;
      alu1_vld_q    <= alu1_vld_d;
      mul_vld_q     <= mul_vld_d;
      alu0_addr_q   <= alu0_addr_d;
      alu1_addr_q   <= alu1_addr_d;
      mul_addr_q    <= mul_addr_d;
      ld_addr_q     <= ld_addr_d;
      ld_acc_vld_q  <= ld_acc_vld_d;
      ld_acc_addr_q <= ld_acc_addr_d;
      mul_cnt_q     <= mul_cnt_d;
    end
  assign alu0_vld  = alu0_vld_q;
  assign alu1_vld  = alu1_vld_q;
  assign mul_vld   = mul_vld_q;
  assign ld_vld    = state_q == WAIT;
  assign alu0_addr = alu0_addr_q;
  assign alu1_addr = alu1_addr_q;
  assign mul_addr  = mul_addr_q;
  assign ld_addr   = ld_addr_q;
  assign mul_busy  = mul_cnt_q > 4'd1;
endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed vectors with hand-computed grants for issue_sched.
module tb_issue_sched;
  localparam int N  = 16;
  localparam int AW = 5;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req;
  logic [2*N-1:0]  ety;
  logic [AW*N-1:0] eag;
  logic            flush, lsu_ready;
  logic            alu0_vld, alu1_vld, mul_vld, ld_vld, mul_busy;
  logic [3:0]      alu0_addr, alu1_addr, mul_addr, ld_addr;
  int              n_chk = 0;
  int              n_err = 0;
  always #5 clk = ~clk;
  issue_sched #(.CIQ_DEPTH(N), .AGE_WIDTH(AW), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .req(req), .entry_type(ety), .entry_age(eag),
    .flush(flush), .lsu_ready(lsu_ready),
    .alu0_vld(alu0_vld), .alu1_vld(alu1_vld), .mul_vld(mul_vld), .ld_vld(ld_vld),
    .alu0_addr(alu0_addr), .alu1_addr(alu1_addr), .mul_addr(mul_addr), .ld_addr(ld_addr),
    .mul_busy(mul_busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ent(input int i, input logic [1:0] t, input logic [AW-1:0] a);
    ety[2*i +: 2]   = t;
    eag[AW*i +: AW] = a;
  endtask
  initial begin
    req = '0;
    ety = '1;
    eag = '0;
    flush = 1'b0;
    lsu_ready = 1'b0;
    step();
    step();
    chk("rst_vld", {alu0_vld, alu1_vld, mul_vld, ld_vld}, 4'b0);
    chk("rst_addr", {alu0_addr, alu1_addr, mul_addr, ld_addr}, 16'h0);
    chk("rst_busy", mul_busy, 1'b0);
    ent(0, 2'd0, 5'd7); ent(1, 2'd0, 5'd3); ent(2, 2'd0, 5'd3); ent(3, 2'd0, 5'd9);
    req = 16'h000F;
    #4 rst = 1'b0;
    step();
    chk("alu_p1", {alu0_vld, alu0_addr, alu1_vld, alu1_addr}, {1'b1, 4'd1, 1'b1, 4'd2});
    step();
    chk("alu_p2", {alu0_vld, alu0_addr, alu1_vld, alu1_addr}, {1'b1, 4'd0, 1'b1, 4'd3});
    step();
    chk("alu_p3", {alu0_vld, alu0_addr, alu1_vld, alu1_addr}, {1'b1, 4'd1, 1'b1, 4'd2});
    req = '0;
    step();
    chk("alu_idle", {alu0_vld, alu0_addr, alu1_vld, alu1_addr}, {1'b0, 4'd1, 1'b0, 4'd2});
    ent(4, 2'd1, 5'd4); ent(5, 2'd1, 5'd1);
    req = 16'h0030;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k <= 6) begin
        chk($sformatf("mul_vld_c%0d", k), mul_vld, (k == 1 || k == 4));
        chk($sformatf("mul_busy_c%0d", k), mul_busy, (k == 1 || k == 2 || k == 4 || k == 5));
      end
      if (k == 1 || k == 4) chk($sformatf("mul_addr_c%0d", k), mul_addr, 4'd5);
    end
    req = '0;
    step(); step(); step();
    chk("mul_drain", {mul_busy, mul_vld}, 2'b00);
    ent(6, 2'd2, 5'd3); ent(7, 2'd2, 5'd8);
    req = 16'h00C0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("ld_hold_c%0d", k), {ld_vld, ld_addr}, {1'b1, 4'd6});
    end
    lsu_ready = 1'b1;
    step();
    chk("ld_b2b", {ld_vld, ld_addr}, {1'b1, 4'd7});
    step();
    chk("ld_no_regrant", {ld_vld, ld_addr}, {1'b0, 4'd7});
    lsu_ready = 1'b0;
    step();
    chk("ld_regrant", {ld_vld, ld_addr}, {1'b1, 4'd6});
    req = 16'h0080;
    step();
    chk("ld_req_drop", {ld_vld, ld_addr}, {1'b1, 4'd6});
    req = 16'h0050;
    step();
    chk("pre_flush_mul", {mul_vld, mul_addr, mul_busy}, {1'b1, 4'd4, 1'b1});
    chk("pre_flush_ld", {ld_vld, ld_addr}, {1'b1, 4'd6});
    flush = 1'b1;
    req = 16'h0051;
    step();
    chk("flush_vld", {alu0_vld, alu1_vld, mul_vld, ld_vld}, 4'b0);
    chk("flush_busy", mul_busy, 1'b0);
    flush = 1'b0;
    step();
    chk("post_flush_mul", {mul_vld, mul_addr, mul_busy}, {1'b1, 4'd4, 1'b1});
    chk("post_flush_ld", {ld_vld, ld_addr}, {1'b1, 4'd6});
    chk("post_flush_alu", {alu0_vld, alu0_addr, alu1_vld}, {1'b1, 4'd0, 1'b0});
    #3 rst = 1'b1;
    #1;
    chk("arst_vld", {alu0_vld, alu1_vld, mul_vld, ld_vld}, 4'b0);
    chk("arst_addr", {alu0_addr, alu1_addr, mul_addr, ld_addr}, 16'h0);
    chk("arst_busy", mul_busy, 1'b0);
    #1 rst = 1'b0;
    step();
    chk("arst_rel_alu", {alu0_vld, alu0_addr}, {1'b1, 4'd0});
    chk("arst_rel_ld", {ld_vld, ld_addr}, {1'b1, 4'd6});
    chk("arst_rel_mul", {mul_vld, mul_addr}, {1'b1, 4'd4});
    ety = '1;
    req = 16'hFFFF;
    flush = 1'b1;
    step();
    flush = 1'b0;
    lsu_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("type3_c%0d", k), {alu0_vld, alu1_vld, mul_vld, ld_vld, mul_busy}, 5'b0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
